// File: rtl/gate_pkg.sv
// Shared types and helpers for the gate motor controller.
package gate_pkg;

    // 3-bit state encoding; CLOSED must stay 0 so a reset register reads as closed.
    typedef enum logic [2:0] {
        CLOSED    = 3'd0,
        OPENING   = 3'd1,
        OPEN_HOLD = 3'd2,
        CLOSING   = 3'd3,
        REVERSE   = 3'd4,
        FAULT     = 3'd5
    } gate_state_t;

    // Red LED half-period while latched in FAULT.
    localparam int BLINK_PERIOD = 8;

    typedef struct packed {
        logic green;
        logic blue;
        logic red;
    } led_t;

    // Steady LED pattern per state; FAULT blinking is handled by the caller.
    function automatic led_t state_leds(input gate_state_t s);
        led_t l;
        l = '0;
        case (s)
            OPENING:   l.green = 1'b1;
            OPEN_HOLD: l.blue  = 1'b1;
            CLOSING:   l.red   = 1'b1;
            default:   l = '0;
        endcase
        return l;
    endfunction

endpackage

// File: rtl/gate_debounce.sv
// Two-flop synchroniser followed by a stability counter. The output only
// follows the synchronised input after DEBOUNCE_CYCLES consecutive samples
// that disagree with the current output.
module gate_debounce #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic dout
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1;
    logic          sync2;
    logic [CW-1:0] cnt;

    // Bring the asynchronous input into the clk domain.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= din;
            sync2 <= sync1;
        end
    end

    // Count disagreeing samples; any agreeing sample restarts the run.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt  <= '0;
            dout <= 1'b0;
        end else if (sync2 == dout) begin
            cnt <= '0;
        end else if (cnt >= LAST) begin
            dout <= sync2;
            cnt  <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/gate_motor_ctrl.sv
// Gate drive sequencer: limit-switch confirmed open/close, open-hold while
// traffic is present, reversal on obstruction, latched fault on timeouts or
// contradictory limit switches.
module gate_motor_ctrl
    import gate_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int HOLD_CYCLES     = 10,
    parameter int MOVE_TIMEOUT    = 50,
    parameter int DEAD_CYCLES     = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sensor,
    input  logic       limit_open,
    input  logic       limit_closed,
    input  logic       obstruction,
    input  logic       fault_clr,
    output logic       motor_open,
    output logic       motor_close,
    output logic       green_led,
    output logic       blue_led,
    output logic       red_led,
    output logic       fault,
    output logic [2:0] state_o
);
    localparam int MAX_A = (HOLD_CYCLES > MOVE_TIMEOUT) ? HOLD_CYCLES : MOVE_TIMEOUT;
    localparam int MAX_B = (DEAD_CYCLES > DEBOUNCE_CYCLES) ? DEAD_CYCLES : DEBOUNCE_CYCLES;
    localparam int MAX_P = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int CW    = $clog2(MAX_P + 1);

    localparam logic [CW-1:0] MOVE_LAST = CW'(MOVE_TIMEOUT - 1);
    localparam logic [CW-1:0] DEAD_LAST = CW'(DEAD_CYCLES - 1);
    localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLD_CYCLES);
    localparam logic [2:0]    BLINK_LAST = 3'(BLINK_PERIOD - 1);

    gate_state_t   state;
    gate_state_t   nxt;
    logic [CW-1:0] cnt;    // move / dead-time / drift counter, cleared on every state change
    logic [CW-1:0] hold;   // open-hold countdown
    logic [2:0]    blink;
    logic          sensor_db;
    logic          presence;
    led_t          leds_nxt;

    gate_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_sensor_db (
        .clk   (clk),
        .reset (reset),
        .din   (sensor),
        .dout  (sensor_db)
    );

    assign presence = sensor_db | obstruction;
    assign leds_nxt = state_leds(nxt);
    assign state_o  = state;

    // Next-state decision; contradictory limits override everything.
    always_comb begin
        nxt = state;
        if (limit_open && limit_closed) begin
            nxt = FAULT;
        end else begin
            case (state)
                CLOSED: begin
                    if (sensor_db)                           nxt = OPENING;
                    else if (!limit_closed && cnt >= MOVE_LAST) nxt = FAULT;
                end
                OPENING: begin
                    if (limit_open)             nxt = OPEN_HOLD;
                    else if (cnt >= MOVE_LAST)  nxt = FAULT;
                end
                OPEN_HOLD: begin
                    if (!presence && hold <= CW'(1)) nxt = CLOSING;
                end
                CLOSING: begin
                    if (presence)               nxt = REVERSE;
                    else if (limit_closed)      nxt = CLOSED;
                    else if (cnt >= MOVE_LAST)  nxt = FAULT;
                end
                REVERSE: begin
                    if (cnt >= DEAD_LAST)       nxt = OPENING;
                end
                FAULT: begin
                    if (fault_clr)              nxt = limit_closed ? CLOSED : OPENING;
                end
                default:                        nxt = FAULT;
            endcase
        end
    end

    // State, counters and registered outputs decoded from the next state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= CLOSED;
            cnt         <= '0;
            hold        <= '0;
            blink       <= '0;
            motor_open  <= 1'b0;
            motor_close <= 1'b0;
            green_led   <= 1'b0;
            blue_led    <= 1'b0;
            red_led     <= 1'b0;
            fault       <= 1'b0;
        end else begin
            state <= nxt;

            if (nxt != state) begin
                cnt  <= '0;
                hold <= HOLD_LOAD;
            end else if (state == CLOSED) begin
                // Consecutive cycles with the closed limit released (drift).
                cnt <= limit_closed ? '0 : ((&cnt) ? cnt : cnt + CW'(1));
            end else if (state == OPEN_HOLD) begin
                hold <= presence ? HOLD_LOAD : ((hold != '0) ? hold - CW'(1) : hold);
            end else begin
                cnt <= (&cnt) ? cnt : cnt + CW'(1);
            end

            motor_open  <= (nxt == OPENING);
            motor_close <= (nxt == CLOSING);
            green_led   <= leds_nxt.green;
            blue_led    <= leds_nxt.blue;
            fault       <= (nxt == FAULT);

            // Red is solid while closing; in FAULT it starts lit and toggles every BLINK_PERIOD.
            if (nxt == FAULT) begin
                if (state != FAULT) begin
                    red_led <= 1'b1;
                    blink   <= '0;
                end else begin
                    blink <= blink + 3'd1;
                    if (blink == BLINK_LAST) red_led <= ~red_led;
                end
            end else begin
                red_led <= leds_nxt.red;
                blink   <= '0;
            end
        end
    end

endmodule

// File: tb/tb_gate_motor_ctrl.sv
// Self-checking bench: directed scenarios plus a randomized run against a
// behavioural gate model (time-in-state bookkeeping and a sample history).
module tb_gate_motor_ctrl;
    import gate_pkg::*;

    localparam int DEB  = 4;
    localparam int HOLD = 10;
    localparam int MOVE = 50;
    localparam int DEAD = 2;
    localparam int POS_MAX = 6;

    logic clk = 1'b0;
    logic reset, sensor, limit_open, limit_closed, obstruction, fault_clr;
    logic motor_open, motor_close, green_led, blue_led, red_led, fault;
    logic [2:0] state_o;

    int n_checks = 0;
    int n_errors = 0;

    // reference model state
    gate_state_t    ms;
    int             tin, drift, quiet;
    logic           m_db;
    logic [DEB+1:0] hist;

    always #5 clk = ~clk;

    gate_motor_ctrl #(
        .DEBOUNCE_CYCLES(DEB), .HOLD_CYCLES(HOLD), .MOVE_TIMEOUT(MOVE), .DEAD_CYCLES(DEAD)
    ) dut (
        .clk(clk), .reset(reset), .sensor(sensor), .limit_open(limit_open),
        .limit_closed(limit_closed), .obstruction(obstruction), .fault_clr(fault_clr),
        .motor_open(motor_open), .motor_close(motor_close), .green_led(green_led),
        .blue_led(blue_led), .red_led(red_led), .fault(fault), .state_o(state_o)
    );

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Motors must never be driven both ways.
    always @(negedge clk) if (!reset) check("mutex", {15'd0, motor_open & motor_close}, 16'd0);

    function automatic logic [15:0] dut_outs();
        return {7'd0, motor_open, motor_close, green_led, blue_led, red_led, fault, state_o};
    endfunction

    function automatic logic [15:0] exp_outs();
        logic r;
        r = (ms == CLOSING) || (ms == FAULT && ((tin / 8) % 2 == 0));
        return {7'd0, ms == OPENING, ms == CLOSING, ms == OPENING, ms == OPEN_HOLD,
                r, ms == FAULT, ms};
    endfunction

    task automatic model_reset();
        ms = CLOSED; tin = 0; drift = 0; quiet = 0; m_db = 1'b0; hist = '0;
    endtask

    // One clock edge of the gate behaviour as described by its rules.
    task automatic model_edge();
        gate_state_t nx;
        tin++;
        nx = ms;
        if (limit_open && limit_closed) nx = FAULT;
        else case (ms)
            CLOSED: begin
                drift = limit_closed ? 0 : drift + 1;
                if (m_db) nx = OPENING;
                else if (drift >= MOVE) nx = FAULT;
            end
            OPENING:   if (limit_open) nx = OPEN_HOLD; else if (tin >= MOVE) nx = FAULT;
            OPEN_HOLD: begin
                quiet = (m_db || obstruction) ? 0 : quiet + 1;
                if (quiet >= HOLD) nx = CLOSING;
            end
            CLOSING: begin
                if (m_db || obstruction) nx = REVERSE;
                else if (limit_closed) nx = CLOSED;
                else if (tin >= MOVE) nx = FAULT;
            end
            REVERSE:   if (tin >= DEAD) nx = OPENING;
            FAULT:     if (fault_clr) nx = limit_closed ? CLOSED : OPENING;
            default:   nx = FAULT;
        endcase
        if (nx != ms) begin tin = 0; drift = 0; quiet = 0; end
        ms = nx;
        // sensor seen by the debouncer lags the raw pin by two edges
        hist = {hist[DEB:0], sensor};
        if (hist[DEB+1:2] == {DEB{~m_db}}) m_db = ~m_db;
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            model_edge();
            #1;
            check("outs", dut_outs(), exp_outs());
        end
    endtask

    task automatic run_until(input gate_state_t s, input int budget);
        int n = 0;
        while (ms != s && n < budget) begin
            step(1);
            n++;
        end
        check("reach", {13'd0, state_o}, {13'd0, s});
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        model_reset();
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        int pos, jam;
        sensor = 0; limit_open = 0; limit_closed = 1; obstruction = 0; fault_clr = 0;
        reset = 1;
        model_reset();
        repeat (2) @(posedge clk);
        #1 check("reset", dut_outs(), 16'd0);
        @(negedge clk) reset = 0;

        // open on debounced presence, stop on open limit
        sensor = 1;
        step(6); check("db_wait", {13'd0, state_o}, {13'd0, CLOSED});
        step(1); check("open_go", {15'd0, motor_open}, 16'd1);
        limit_closed = 0; step(4);
        limit_open = 1; step(1); check("hold", {14'd0, motor_open, blue_led}, 16'd1);

        // presence gone: debounce + hold time, then close onto the closed limit
        sensor = 0;
        step(15); check("hold_end", {13'd0, state_o}, {13'd0, OPEN_HOLD});
        step(1);  check("closing", {15'd0, motor_close}, 16'd1);
        limit_open = 0; step(3);
        limit_closed = 1; step(1);
        check("closed", {12'd0, green_led, blue_led, red_led, motor_close}, 16'd0);

        // obstruction while closing: dead time then reopen
        sensor = 1; run_until(OPENING, 20);
        sensor = 0; limit_closed = 0; limit_open = 1; step(1);
        limit_open = 0; run_until(CLOSING, 40);
        obstruction = 1; step(1);
        check("rev0", {14'd0, motor_open, motor_close}, 16'd0);
        obstruction = 0; step(1);
        check("rev1", {14'd0, motor_open, motor_close}, 16'd0);
        step(1);
        check("rev_open", {14'd0, motor_open, motor_close}, 16'd2);

        // asynchronous reset mid-motion drops the motor without a clock
        #2 reset = 1;
        #1 check("async_rst", {11'd0, motor_open, motor_close, state_o}, 16'd0);
        model_reset();
        limit_closed = 1; limit_open = 0;
        @(negedge clk) reset = 0;

        // a 3-cycle glitch must not get through the debouncer
        sensor = 1; step(3);
        sensor = 0; step(8);
        check("glitch", {13'd0, state_o}, {13'd0, CLOSED});

        // open travel timeout, fault blink, clear onto closed limit
        sensor = 1; run_until(OPENING, 20);
        sensor = 0; limit_closed = 0;
        step(49); check("to_wait", {13'd0, state_o}, {13'd0, OPENING});
        step(1);  check("timeout", {14'd0, fault, red_led}, 16'd3);
        step(8);  check("blink", {15'd0, red_led}, 16'd0);
        limit_closed = 1; fault_clr = 1; step(1); fault_clr = 0;
        check("clr", {12'd0, fault, state_o}, {12'd0, 1'b0, CLOSED});

        // both limits in OPEN_HOLD; clear ignored while both remain active
        sensor = 1; run_until(OPENING, 20);
        limit_closed = 0; limit_open = 1; step(1);
        check("hold2", {13'd0, state_o}, {13'd0, OPEN_HOLD});
        limit_closed = 1; step(1); check("both", {15'd0, fault}, 16'd1);
        fault_clr = 1; step(1); check("clr_ign", {13'd0, state_o}, {13'd0, FAULT});
        limit_open = 0; step(1); fault_clr = 0;
        check("clr_ok", {13'd0, state_o}, {13'd0, CLOSED});

        // randomized traffic against a simple gate plant
        sensor = 0; obstruction = 0; limit_open = 0; limit_closed = 1;
        pulse_reset();
        pos = 0; jam = 0;
        for (int c = 0; c < 3000; c++) begin
            if (jam > 0) jam--;
            else if ($urandom_range(0, 199) == 0) jam = 60;
            if (jam == 0) begin
                if (ms == OPENING && pos < POS_MAX) pos++;
                else if (ms == CLOSING && pos > 0) pos--;
            end
            limit_open   = (pos == POS_MAX);
            limit_closed = (pos == 0);
            if ($urandom_range(0, 59) == 0) begin limit_open = 1; limit_closed = 1; end
            if ($urandom_range(0, 11) == 0) sensor = ~sensor;
            obstruction = ($urandom_range(0, 29) == 0);
            fault_clr   = ($urandom_range(0, 7) == 0);
            step(1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/gate_motor_ctrl.md
Name: gate_motor_ctrl

Overview:
Sequencing controller for the automatic gate's drive motor. Debounces the presence sensor, drives open/close motor enables against limit switches, holds the gate open while traffic is present, reverses on obstruction, and latches a fault on travel timeout or inconsistent limits. Sits between the raw field inputs and the motor driver/LED indicators; it replaces free-running timed phases with limit-switch-confirmed motion.

Parameters:
DEBOUNCE_CYCLES, 4, consecutive stable samples required before the synchronised sensor level is accepted
HOLD_CYCLES, 10, open-hold time after the last debounced presence
MOVE_TIMEOUT, 50, max cycles in OPENING or CLOSING before FAULT
DEAD_CYCLES, 2, motor-off gap before any direction reversal

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
sensor  in  1  raw presence sensor, asynchronous to clk
limit_open  in  1  fully-open limit switch, synchronous
limit_closed  in  1  fully-closed limit switch, synchronous
obstruction  in  1  safety beam broken, synchronous, level
fault_clr  in  1  single-cycle fault acknowledge
motor_open  out  1  drive motor in open direction
motor_close  out  1  drive motor in close direction
green_led  out  1  OPENING
blue_led  out  1  OPEN_HOLD
red_led  out  1  CLOSING, or FAULT (blinks every 8 cycles in FAULT)
fault  out  1  latched fault flag
state_o  out  3  current state encoding, for debug

Behaviour:
- Reset: state CLOSED; all outputs 0; counters 0; sensor synchroniser and debounced level 0.
- Sensor path: 2-FF synchroniser -> debounce counter; sensor_db changes only after DEBOUNCE_CYCLES consecutive equal samples differing from current sensor_db. Latency raw -> sensor_db = 2 + DEBOUNCE_CYCLES cycles.
- Motor outputs are registered and decoded from state; motor_open and motor_close are never 1 together (hard requirement, assert in bench).
- States: CLOSED, OPENING, OPEN_HOLD, CLOSING, REVERSE, FAULT.
- CLOSED: motors off. sensor_db=1 -> OPENING. limit_closed=0 for >= MOVE_TIMEOUT cycles (gate drifted) -> FAULT.
- OPENING: motor_open=1; move counter increments. limit_open=1 -> OPEN_HOLD (motor off the following cycle). Counter reaches MOVE_TIMEOUT -> FAULT.
- OPEN_HOLD: hold counter loaded with HOLD_CYCLES on entry and reloaded every cycle sensor_db=1 or obstruction=1; decrements otherwise; at 0 -> CLOSING.
- CLOSING: motor_close=1. sensor_db=1 or obstruction=1 -> REVERSE (takes priority over limit_closed in the same cycle). limit_closed=1 -> CLOSED. Timeout -> FAULT.
- REVERSE: motors off for DEAD_CYCLES, then OPENING with move counter cleared.
- Any state: limit_open=1 and limit_closed=1 together -> FAULT (highest priority after reset).
- FAULT: motors off, fault=1, red_led toggles every 8 cycles. fault_clr=1 with both limits not simultaneously active -> CLOSED if limit_closed=1, else OPENING. fault_clr in other states ignored.
- Counter widths: $clog2(max param + 1); counters saturate, never wrap.
- Reset mid-motion: motors drop to 0 asynchronously; no state retained.

Decomposition:
- gate_pkg: state enum (3-bit encoding, CLOSED=0), LED blink period constant, state-to-LED decode function.
- One sub-module: gate_debounce (synchroniser + debounce counter, parameter DEBOUNCE_CYCLES), reusable for limit switches later.

Test Plan:
- Reset then sensor=1 held: sensor_db at cycle 6; OPENING, motor_open=1; limit_open at +5 -> OPEN_HOLD, motor_open=0 next cycle, blue_led=1.
- Sensor drops in OPEN_HOLD: after debounce + 10 cycles -> CLOSING, motor_close=1; limit_closed -> CLOSED, all LEDs 0.
- Obstruction=1 mid-CLOSING: motor_close=0 next cycle, both motors 0 for 2 cycles, then motor_open=1.
- Sensor glitch of 3 cycles in CLOSED: sensor_db stays 0, no state change.
- OPENING with no limit_open: at 50 cycles -> FAULT, fault=1, red_led blinking; fault_clr with limit_closed=1 -> CLOSED, fault=0.
- limit_open=limit_closed=1 in OPEN_HOLD -> FAULT next cycle; fault_clr while both still high ignored.
